// File: rtl/ce361_ctrl_pkg.sv
// Shared types and encodings for the CE361 multicycle and single-cycle control units.
package ce361_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_WB_R,
    ST_EXEC_I,
    ST_WB_I,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_WB_MEM,
    ST_MEM_WR,
    ST_BRANCH,
    ST_JUMP,
    ST_FAULT
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUN_ADD = 6'b100000;
  localparam logic [5:0] FUN_SUB = 6'b100010;
  localparam logic [5:0] FUN_AND = 6'b100100;
  localparam logic [5:0] FUN_OR  = 6'b100101;
  localparam logic [5:0] FUN_SLT = 6'b101010;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// Opcode/funct to ALU operation and legality; also used by the single-cycle control.
module alu_decode
  import ce361_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fun,
  output logic [2:0] alu_ctr,
  output logic       legal
);

  always_comb begin
    alu_ctr = ALU_ADD;
    legal   = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (fun)
          FUN_ADD: alu_ctr = ALU_ADD;
          FUN_SUB: alu_ctr = ALU_SUB;
          FUN_AND: alu_ctr = ALU_AND;
          FUN_OR:  alu_ctr = ALU_OR;
          FUN_SLT: alu_ctr = ALU_SLT;
          default: legal   = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_J: alu_ctr = ALU_ADD;
      OP_ORI:                      alu_ctr = ALU_OR;
      OP_BEQ, OP_BNE:              alu_ctr = ALU_SUB;
      default:                     legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer for the CE361 MIPS-subset datapath with a shared,
// variable-latency instruction/data memory.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | one cycle after reset, then FETCH
// FETCH     | read instruction at PC; IR and PC+4 load on mem_ready
// DECODE    | latch opcode and ALU op, dispatch or flag illegal
// EXEC_R    | R-type ALU operation, rt operand
// WB_R      | write rd with ALU result, retire
// EXEC_I    | addi/ori with immediate operand
// WB_I      | write rt with ALU result, retire
// MEM_ADDR  | base + sign-extended offset
// MEM_RD    | load data access, wait for mem_ready
// WB_MEM    | write rt with memory data, retire
// MEM_WR    | store data access, retire on mem_ready
// BRANCH    | compare rs/rt, load branch target when taken, retire
// JUMP      | load jump target, retire
// FAULT     | halted until reset, fault_code holds the cause
module multicycle_control
  import ce361_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic [5:0] Op,
  input  logic [5:0] Fun,
  input  logic       equal,
  input  logic       sign,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       IRWr,
  output logic       PCWr,
  output logic       nPC_sel,
  output logic       Jump,
  output logic       RegWr,
  output logic       RegDst,
  output logic       ExtOp,
  output logic       ALUSrc,
  output logic [2:0] ALUctr,
  output logic       MemWr,
  output logic       MemtoReg,
  output logic       retire,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_t     state;
  logic [5:0] op_r;
  logic [2:0] alu_ctr_r;
  logic [7:0] wait_cnt;
  logic [1:0] fault_code_r;
  logic [2:0] alu_ctr_dec;
  logic       legal_dec;
  logic       mem_phase;
  logic [7:0] wait_next;
  logic       wait_hit;
  logic       taken;

  // The ALU sign bit is consumed by the datapath's slt path, not by sequencing.
  logic unused_sign;
  assign unused_sign = sign;

  alu_decode u_alu_decode (
    .op      (Op),
    .fun     (Fun),
    .alu_ctr (alu_ctr_dec),
    .legal   (legal_dec)
  );

  assign mem_phase = is_mem_state(state);
  assign wait_next = wait_cnt + 8'd1;
  // This cycle is the WAIT_LIMIT-th consecutive one without mem_ready.
  assign wait_hit  = mem_phase && !mem_ready && (wait_next == LIMIT);
  assign taken     = (op_r == OP_BEQ) ? equal : !equal;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state        <= ST_IDLE;
      op_r         <= OP_RTYPE;
      alu_ctr_r    <= ALU_ADD;
      wait_cnt     <= 8'd0;
      fault_code_r <= FC_NONE;
    end else begin
      wait_cnt <= (mem_phase && !mem_ready && !wait_hit) ? wait_next : 8'd0;
      case (state)
        ST_IDLE: state <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ready) begin
            state <= ST_DECODE;
          end else if (wait_hit) begin
            state        <= ST_FAULT;
            fault_code_r <= FC_TIMEOUT;
          end
        end
        ST_DECODE: begin
          op_r      <= Op;
          alu_ctr_r <= alu_ctr_dec;
          if (!legal_dec) begin
            state        <= ST_FAULT;
            fault_code_r <= FC_ILLEGAL;
          end else begin
            case (Op)
              OP_RTYPE:       state <= ST_EXEC_R;
              OP_ADDI, OP_ORI: state <= ST_EXEC_I;
              OP_LW, OP_SW:   state <= ST_MEM_ADDR;
              OP_BEQ, OP_BNE: state <= ST_BRANCH;
              OP_J:           state <= ST_JUMP;
              default: begin
                state        <= ST_FAULT;
                fault_code_r <= FC_ILLEGAL;
              end
            endcase
          end
        end
        ST_EXEC_R:   state <= ST_WB_R;
        ST_EXEC_I:   state <= ST_WB_I;
        ST_MEM_ADDR: state <= (op_r == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
        ST_MEM_RD, ST_MEM_WR: begin
          if (mem_ready) begin
            state <= (state == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
          end else if (wait_hit) begin
            state        <= ST_FAULT;
            fault_code_r <= FC_TIMEOUT;
          end
        end
        ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: state <= ST_FETCH;
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    IorD       = 1'b0;
    IRWr       = 1'b0;
    PCWr       = 1'b0;
    nPC_sel    = 1'b0;
    Jump       = 1'b0;
    RegWr      = 1'b0;
    RegDst     = 1'b0;
    ExtOp      = 1'b0;
    ALUSrc     = 1'b0;
    ALUctr     = ALU_ADD;
    MemWr      = 1'b0;
    MemtoReg   = 1'b0;
    retire     = 1'b0;
    fault      = 1'b0;
    fault_code = FC_NONE;
    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        IRWr    = mem_ready;
        PCWr    = mem_ready;
      end
      ST_EXEC_R: ALUctr = alu_ctr_r;
      ST_WB_R: begin
        RegWr  = 1'b1;
        RegDst = 1'b1;
        retire = 1'b1;
      end
      ST_EXEC_I: begin
        ALUSrc = 1'b1;
        ExtOp  = (op_r == OP_ADDI);
        ALUctr = alu_ctr_r;
      end
      ST_WB_I: begin
        RegWr  = 1'b1;
        retire = 1'b1;
      end
      ST_MEM_ADDR: begin
        ALUSrc = 1'b1;
        ExtOp  = 1'b1;
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      ST_WB_MEM: begin
        RegWr    = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      ST_MEM_WR: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        MemWr   = 1'b1;
        retire  = mem_ready;
      end
      ST_BRANCH: begin
        ALUctr  = ALU_SUB;
        PCWr    = taken;
        nPC_sel = taken;
        retire  = 1'b1;
      end
      ST_JUMP: begin
        PCWr   = 1'b1;
        Jump   = 1'b1;
        retire = 1'b1;
      end
      ST_FAULT: begin
        fault      = 1'b1;
        fault_code = fault_code_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction table with a latency/control-word
// scoreboard, plus hand sequences for wait states, faults and async reset.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic [5:0] Op = 6'd0;
  logic [5:0] Fun = 6'd0;
  logic       equal = 1'b0;
  logic       sign = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, IorD, IRWr, PCWr, nPC_sel, Jump, RegWr, RegDst;
  logic       ExtOp, ALUSrc, MemWr, MemtoReg, retire, fault;
  logic [2:0] ALUctr;
  logic [1:0] fault_code;

  multicycle_control #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .nReset(nReset), .Op(Op), .Fun(Fun), .equal(equal), .sign(sign),
    .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .IRWr(IRWr), .PCWr(PCWr),
    .nPC_sel(nPC_sel), .Jump(Jump), .RegWr(RegWr), .RegDst(RegDst), .ExtOp(ExtOp),
    .ALUSrc(ALUSrc), .ALUctr(ALUctr), .MemWr(MemWr), .MemtoReg(MemtoReg),
    .retire(retire), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {mem_req, IorD, IRWr, PCWr, nPC_sel, Jump, RegWr, RegDst, ExtOp, ALUSrc,
                ALUctr, MemWr, MemtoReg, retire, fault, fault_code};

  localparam logic [18:0] K_REQ    = 19'd1 << 18;
  localparam logic [18:0] K_IORD   = 19'd1 << 17;
  localparam logic [18:0] K_IRWR   = 19'd1 << 16;
  localparam logic [18:0] K_PCWR   = 19'd1 << 15;
  localparam logic [18:0] K_NPC    = 19'd1 << 14;
  localparam logic [18:0] K_JMP    = 19'd1 << 13;
  localparam logic [18:0] K_REGWR  = 19'd1 << 12;
  localparam logic [18:0] K_REGDST = 19'd1 << 11;
  localparam logic [18:0] K_EXT    = 19'd1 << 10;
  localparam logic [18:0] K_SRC    = 19'd1 << 9;
  localparam logic [18:0] K_MEMWR  = 19'd1 << 5;
  localparam logic [18:0] K_M2R    = 19'd1 << 4;
  localparam logic [18:0] K_RET    = 19'd1 << 3;
  localparam logic [18:0] K_FLT    = 19'd1 << 2;
  localparam logic [18:0] W_FETCH  = K_REQ | K_IRWR | K_PCWR;
  localparam logic [18:0] W_WBR    = K_REGWR | K_REGDST | K_RET;
  localparam logic [18:0] W_WBI    = K_REGWR | K_RET;
  localparam logic [18:0] W_WBM    = K_REGWR | K_M2R | K_RET;
  localparam logic [18:0] W_SW     = K_REQ | K_IORD | K_MEMWR;

  function automatic logic [18:0] alu(input logic [2:0] a);
    return {10'd0, a, 6'd0};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fun;
    logic        eq;
    int          lat;
    logic [18:0] w3;
    logic [18:0] wret;
    int          pcw;
  } vec_t;

  typedef struct {
    int          lat;
    logic [18:0] w1;
    logic [18:0] w3;
    logic [18:0] wret;
    int          irw;
    int          pcw;
  } exp_t;

  localparam int NV = 15;
  vec_t vecs[NV];
  exp_t sb[$];
  exp_t e;

  int errors = 0;
  int checks = 0;

  int          lat, irw, pcw, req, io, bad;
  logic [18:0] w1, w3, wret;
  logic        flt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nReset = 1'b0;
    #1 chk("reset_outputs", 32'(obs), 32'd0);
    @(negedge clk);
    nReset = 1'b1;
    #1 chk("idle_after_release", 32'(obs), 32'd0);
  endtask

  // Runs one instruction from FETCH entry until retire, fault or a 60-cycle budget.
  // rdy[c-1] is mem_ready during cycle c.
  task automatic run(input logic [5:0] t_op, input logic [5:0] t_fun, input logic t_eq,
                     input logic [63:0] rdy,
                     output int o_lat, output logic [18:0] o_w1, output logic [18:0] o_w3,
                     output logic [18:0] o_wret, output int o_irw, output int o_pcw,
                     output int o_req, output int o_io, output logic o_flt);
    Op = t_op; Fun = t_fun; equal = t_eq;
    o_lat = 0; o_w1 = '1; o_w3 = '1; o_wret = '1;
    o_irw = 0; o_pcw = 0; o_req = 0; o_io = 0; o_flt = 1'b0;
    while (o_lat < 60) begin
      @(negedge clk);
      mem_ready = rdy[o_lat];
      o_lat++;
      #1;
      if (o_lat == 1) o_w1 = obs;
      if (o_lat == 3) o_w3 = obs;
      o_irw += int'(IRWr);
      o_pcw += int'(PCWr);
      o_req += int'(mem_req);
      o_io  += int'(mem_req & IorD);
      if (retire || fault) begin
        o_wret = obs;
        o_flt  = fault;
        break;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{6'h00, 6'h20, 1'b0, 4, alu(3'd0), W_WBR, 1};
    vecs[1]  = '{6'h00, 6'h22, 1'b0, 4, alu(3'd1), W_WBR, 1};
    vecs[2]  = '{6'h00, 6'h24, 1'b1, 4, alu(3'd2), W_WBR, 1};
    vecs[3]  = '{6'h00, 6'h25, 1'b0, 4, alu(3'd3), W_WBR, 1};
    vecs[4]  = '{6'h00, 6'h2A, 1'b0, 4, alu(3'd4), W_WBR, 1};
    vecs[5]  = '{6'h08, 6'h00, 1'b0, 4, K_SRC | K_EXT, W_WBI, 1};
    vecs[6]  = '{6'h0D, 6'h22, 1'b0, 4, K_SRC | alu(3'd3), W_WBI, 1};
    vecs[7]  = '{6'h23, 6'h00, 1'b0, 5, K_SRC | K_EXT, W_WBM, 1};
    vecs[8]  = '{6'h2B, 6'h00, 1'b0, 4, K_SRC | K_EXT, W_SW | K_RET, 1};
    vecs[9]  = '{6'h04, 6'h00, 1'b1, 3, K_PCWR | K_NPC | alu(3'd1) | K_RET,
                 K_PCWR | K_NPC | alu(3'd1) | K_RET, 2};
    vecs[10] = '{6'h04, 6'h00, 1'b0, 3, alu(3'd1) | K_RET, alu(3'd1) | K_RET, 1};
    vecs[11] = '{6'h05, 6'h00, 1'b0, 3, K_PCWR | K_NPC | alu(3'd1) | K_RET,
                 K_PCWR | K_NPC | alu(3'd1) | K_RET, 2};
    vecs[12] = '{6'h05, 6'h00, 1'b1, 3, alu(3'd1) | K_RET, alu(3'd1) | K_RET, 1};
    vecs[13] = '{6'h02, 6'h00, 1'b0, 3, K_PCWR | K_JMP | K_RET, K_PCWR | K_JMP | K_RET, 2};
    vecs[14] = '{6'h00, 6'h20, 1'b0, 4, alu(3'd0), W_WBR, 1};

    do_reset();

    // Back-to-back instructions with zero memory wait.
    for (int i = 0; i < NV; i++) begin
      sb.push_back('{vecs[i].lat, W_FETCH, vecs[i].w3, vecs[i].wret, 1, vecs[i].pcw});
      run(vecs[i].op, vecs[i].fun, vecs[i].eq, '1, lat, w1, w3, wret, irw, pcw, req, io, flt);
      e = sb.pop_front();
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(e.lat));
      chk($sformatf("vec%0d_fetch_word", i), 32'(w1), 32'(e.w1));
      chk($sformatf("vec%0d_cycle3_word", i), 32'(w3), 32'(e.w3));
      chk($sformatf("vec%0d_retire_word", i), 32'(wret), 32'(e.wret));
      chk($sformatf("vec%0d_irwr_count", i), 32'(irw), 32'(e.irw));
      chk($sformatf("vec%0d_pcwr_count", i), 32'(pcw), 32'(e.pcw));
    end

    // lw with three wait cycles in MEM_RD; ready low in DECODE/MEM_ADDR is ignored.
    run(6'h23, 6'h00, 1'b0, ~64'h3E, lat, w1, w3, wret, irw, pcw, req, io, flt);
    chk("lw_wait_latency", 32'(lat), 32'd8);
    chk("lw_wait_data_req_cycles", 32'(io), 32'd4);
    chk("lw_wait_retire_word", 32'(wret), 32'(W_WBM));

    // Illegal opcode.
    do_reset();
    run(6'h3F, 6'h00, 1'b0, '1, lat, w1, w3, wret, irw, pcw, req, io, flt);
    chk("illegal_op_cycle", 32'(lat), 32'd3);
    chk("illegal_op_word", 32'(wret), 32'(K_FLT | 19'd1));
    Op = 6'h00; Fun = 6'h20;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mem_ready = c[0];
      #1;
      if (obs !== (K_FLT | 19'd1)) bad++;
    end
    chk("fault_absorbing_cycles_off", 32'(bad), 32'd0);

    // Illegal funct under R-type opcode.
    do_reset();
    run(6'h00, 6'h00, 1'b0, '1, lat, w1, w3, wret, irw, pcw, req, io, flt);
    chk("illegal_fun_word", 32'(wret), 32'(K_FLT | 19'd1));

    // Fetch timeout with WAIT_LIMIT=4.
    do_reset();
    run(6'h00, 6'h20, 1'b0, 64'd0, lat, w1, w3, wret, irw, pcw, req, io, flt);
    chk("timeout_cycle", 32'(lat), 32'd5);
    chk("timeout_req_cycles", 32'(req), 32'd4);
    chk("timeout_word", 32'(wret), 32'(K_FLT | 19'd2));

    // mem_ready on the last permitted wait cycle: no fault.
    do_reset();
    run(6'h00, 6'h20, 1'b0, ~64'h7, lat, w1, w3, wret, irw, pcw, req, io, flt);
    chk("late_ready_latency", 32'(lat), 32'd7);
    chk("late_ready_no_fault", 32'(flt), 32'd0);
    chk("late_ready_retire_word", 32'(wret), 32'(W_WBR));

    // Async reset while a store is waiting in MEM_WR.
    do_reset();
    Op = 6'h2B; Fun = 6'h00;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      mem_ready = (c == 1);
      #1;
    end
    chk("sw_wait_word", 32'(obs), 32'(W_SW));
    #2 nReset = 1'b0;
    #1 chk("async_reset_outputs", 32'(obs), 32'd0);
    @(negedge clk);
    nReset = 1'b1;
    #1 chk("post_reset_idle", 32'(obs), 32'd0);
    @(negedge clk);
    #1 chk("post_reset_fetch", 32'(obs), 32'(K_REQ));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-style multicycle sequencer for the CE361 MIPS-subset datapath. It replaces the single-cycle combinational control unit when the datapath is run with a shared instruction/data memory. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB states and handshakes with a variable-latency memory (mem_req/mem_ready). It drives the same datapath control signals as the single-cycle unit, plus register enables, and flags illegal opcodes and memory timeouts.

Parameters:
WAIT_LIMIT, 15, max consecutive cycles mem_req may stay high without mem_ready before a timeout fault (range 1..255).

Ports:
clk  in  1  system clock, rising edge
nReset  in  1  asynchronous active-low reset
Op  in  6  opcode field from instruction register
Fun  in  6  funct field from instruction register
equal  in  1  ALU zero flag (rs-rt == 0)
sign  in  1  ALU result sign bit
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
IorD  out  1  memory address select: 0=PC, 1=ALU result
IRWr  out  1  load instruction register
PCWr  out  1  load PC
nPC_sel  out  1  PC source: 0=PC+4, 1=branch target
Jump  out  1  PC source override: jump target
RegWr  out  1  register file write
RegDst  out  1  1=rd, 0=rt
ExtOp  out  1  1=sign-extend imm16, 0=zero-extend
ALUSrc  out  1  1=immediate, 0=rt
ALUctr  out  3  ALU operation
MemWr  out  1  memory write (qualifies mem_req)
MemtoReg  out  1  writeback source: 1=memory data
retire  out  1  one-cycle pulse on an instruction's final cycle
fault  out  1  sticky; controller halted
fault_code  out  2  01=illegal opcode/funct, 10=memory timeout, 00=none

Behaviour:
- Reset: while nReset=0, state=IDLE, wait counter=0, fault_code=00, and every output is 0. IDLE goes to FETCH unconditionally on the next edge. Reset asserted mid-instruction aborts it immediately; no partial writes follow.
- Outputs are decoded from state only, except write enables gated by mem_ready or the branch condition, as listed per state.
- FETCH: mem_req=1, IorD=0. When mem_ready=1: IRWr=1, PCWr=1, nPC_sel=0, and go to DECODE. Otherwise stay.
- DECODE: register the instruction class from Op/Fun. Valid encodings:
  - R-type Op=000000 with Fun add 100000, sub 100010, and 100100, or 100101, slt 101010
  - addi 001000, ori 001101, lw 100011, sw 101011, beq 000100, bne 000101, j 000010
  - Anything else goes to FAULT with code 01.
- EXEC_R: ALUSrc=0, ALUctr from Fun. Next state WB_R.
- WB_R: RegWr=1, RegDst=1, MemtoReg=0, retire=1. Next state FETCH.
- EXEC_I: ALUSrc=1. addi: ExtOp=1, ALUctr=add. ori: ExtOp=0, ALUctr=or. Next state WB_I.
- WB_I: RegWr=1, RegDst=0, MemtoReg=0, retire=1. Next state FETCH.
- MEM_ADDR: ALUSrc=1, ExtOp=1, ALUctr=add. lw goes to MEM_RD; sw goes to MEM_WR.
- MEM_RD: mem_req=1, IorD=1. When mem_ready=1, go to WB_MEM.
- WB_MEM: RegWr=1, RegDst=0, MemtoReg=1, retire=1. Next state FETCH.
- MEM_WR: mem_req=1, IorD=1, MemWr=1. When mem_ready=1: retire=1 and go to FETCH.
- BRANCH: ALUSrc=0, ALUctr=sub. Taken when (beq & equal) | (bne & ~equal); if taken, PCWr=1 and nPC_sel=1. retire=1. Next state FETCH.
- JUMP: PCWr=1, Jump=1, retire=1. Next state FETCH.
- FAULT: all outputs 0 except fault=1 and fault_code. Absorbing until reset.
- ALUctr encoding: add 000, sub 001, and 010, or 011, slt 100. Default 000 in states that do not use the ALU.
- Latency with zero memory wait (mem_ready already high): R/I-type 4 cycles, lw 5, sw 4, beq/bne 3, j 3. Each wait cycle adds 1.
- Wait counter (8 bit):
  - Increments each cycle mem_req=1 & mem_ready=0.
  - Clears when mem_ready=1 or on leaving a memory state.
  - When it reaches WAIT_LIMIT with mem_ready still 0, the controller goes to FAULT with code 10 on the next edge.
  - mem_ready on the same cycle the counter reaches WAIT_LIMIT wins: no fault.
- mem_ready outside a memory state is ignored.
- mem_req, IorD and MemWr stay stable for the whole of a request.

Decomposition:
- Package ce361_ctrl_pkg holds the state enum, the ALUctr encoding constants, and the Op/Fun constants (OP_RTYPE, OP_LW, FUN_ADD, ...).
- One sub-module, alu_decode (combinational): Fun/Op to ALUctr and legality. It is shared with the single-cycle control.

Test Plan:
- R-type add, mem_ready tied 1: Op=000000, Fun=100000 -> retire on cycle 4 after FETCH entry. WB_R shows RegWr=1, RegDst=1, ALUctr=000. Exactly one IRWr and one PCWr.
- lw with 3 wait cycles in MEM_RD: Op=100011 -> mem_req=1 and IorD=1 for 4 cycles, then WB_MEM with MemtoReg=1, RegWr=1. Total 8 cycles.
- beq: equal=1 -> PCWr=1, nPC_sel=1 in BRANCH. Repeat with equal=0 -> PCWr=0, retire=1. bne with equal=0 -> taken.
- Illegal: Op=111111 -> FAULT, fault=1, fault_code=01, RegWr/MemWr/PCWr stay 0 thereafter.
- Timeout: WAIT_LIMIT=4, mem_ready held 0 in FETCH -> fault_code=10 after 4 wait cycles. Second run with mem_ready rising on the 4th cycle -> no fault.
- Async reset during MEM_WR wait: drop nReset mid-cycle -> all outputs 0 immediately (MemWr=0). After release, IDLE then FETCH.
